// File: rtl/reg_write_arbiter_pkg.sv
// Shared definitions for the register write arbiter: FSM state encodings,
// parameter defaults and the requester index width.
package reg_write_arbiter_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int WIDTH_DEF = 8;
    localparam int IDX_W     = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

endpackage

// File: rtl/reg_write_arbiter_rr_select.sv
// Round-robin selector: searches upward from ptr (modulo N_REQ) and reports
// the first requester found together with a valid flag.
module rr_select
    import reg_write_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             valid
);

    logic [IDX_W-1:0] idx;

    // Walk the requesters starting at ptr; the first set bit wins.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = IDX_W'((int'(ptr) + k) % N_REQ);
            if (!valid && req[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Shared-register write arbiter. Requesters compete round-robin; the winner
// is granted for one cycle, its data is written if it still requests, then a
// one-cycle ack is issued. Every output comes straight from a flop.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] wdata,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       ack,
    output logic [WIDTH-1:0]       q,
    output logic [IDX_W-1:0]       owner,
    output logic                   busy
);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   win_q, win_d;
    logic [N_REQ-1:0]   gnt_d, ack_d;
    logic [WIDTH-1:0]   q_d;
    logic [IDX_W-1:0]   owner_d;
    logic               busy_d;

    logic [IDX_W-1:0]   sel_winner;
    logic               sel_valid;

    rr_select #(
        .N_REQ (N_REQ)
    ) u_rr_select (
        .req    (req),
        .ptr    (ptr_q),
        .winner (sel_winner),
        .valid  (sel_valid)
    );

    // State register; reset returns the FSM to IDLE ahead of any transition.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic: a grant completes only if the winner still requests.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (sel_valid) state_d = ST_GRANT;
            ST_GRANT: state_d = req[win_q] ? ST_WRITE : ST_IDLE;
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and the arbitration bookkeeping.
    always_comb begin
        gnt_d   = '0;
        ack_d   = '0;
        q_d     = q;
        owner_d = owner;
        ptr_d   = ptr_q;
        win_d   = win_q;
        busy_d  = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (sel_valid) begin
                    win_d             = sel_winner;
                    gnt_d[sel_winner] = 1'b1;
                end
            end
            ST_GRANT: begin
                // Only the latched winner's request matters here; other
                // requesters are ignored until the FSM is back in IDLE.
                if (req[win_q]) begin
                    q_d          = wdata[int'(win_q)*WIDTH +: WIDTH];
                    owner_d      = win_q;
                    ptr_d        = IDX_W'((int'(win_q) + 1) % N_REQ);
                    ack_d[win_q] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Output and bookkeeping registers, all cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt   <= '0;
            ack   <= '0;
            q     <= '0;
            owner <= '0;
            busy  <= 1'b0;
            ptr_q <= '0;
            win_q <= '0;
        end else begin
            gnt   <= gnt_d;
            ack   <= ack_d;
            q     <= q_d;
            owner <= owner_d;
            busy  <= busy_d;
            ptr_q <= ptr_d;
            win_q <= win_d;
        end
    end

endmodule
